// File: rtl/mips_pkg.sv
// Shared constants for the MIPS PC path: default widths/vectors, instruction
// field positions and the next-PC source encoding.
package mips_pkg;

  localparam int          ADDR_W_DEF       = 32;
  localparam logic [31:0] RESET_VECTOR_DEF = 32'h0000_0000;
  localparam logic [31:0] EXC_VECTOR_DEF   = 32'h8000_0180;

  localparam int IMM_LSB  = 0;
  localparam int IMM_MSB  = 15;
  localparam int JIDX_LSB = 0;
  localparam int JIDX_MSB = 25;
  localparam int RS_LSB   = 21;
  localparam int RS_MSB   = 25;

  localparam logic [4:0] RA_REG = 5'd31;

  typedef enum logic [2:0] {
    SEL_SEQ,
    SEL_BR,
    SEL_J,
    SEL_JR,
    SEL_ERET,
    SEL_EXC
  } npc_sel_e;

endpackage

// File: rtl/ras_stack.sv
// Circular shadow return-address stack. When full, a push overwrites the oldest
// entry; sticky overflow/underflow flags clear only on reset.
module ras_stack #(
  parameter  int ADDR_W    = 32,
  parameter  int RAS_DEPTH = 4,
  localparam int PTR_W     = $clog2(RAS_DEPTH),
  localparam int CNT_W     = PTR_W + 1
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              push,
  input  logic              pop,
  input  logic [ADDR_W-1:0] push_data,
  output logic [ADDR_W-1:0] top,
  output logic [CNT_W-1:0]  count,
  output logic              overflow,
  output logic              underflow
);

  logic [ADDR_W-1:0] mem [RAS_DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  top_ptr;
  logic              full;
  logic              empty;

  assign top_ptr = wr_ptr - PTR_W'(1);
  assign top     = mem[top_ptr];
  assign full    = (count == CNT_W'(RAS_DEPTH));
  assign empty   = (count == '0);

  // Entry storage carries data only, so it has no reset.
  always_ff @(posedge clock) begin
    if (push) begin
      if (pop) begin
        if (!empty) mem[top_ptr] <= push_data;
      end else begin
        mem[wr_ptr] <= push_data;
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr    <= '0;
      count     <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      case ({push, pop})
        2'b10: begin
          wr_ptr <= wr_ptr + PTR_W'(1);
          if (full) overflow <= 1'b1;
          else      count    <= count + CNT_W'(1);
        end
        2'b01: begin
          if (empty) begin
            underflow <= 1'b1;
          end else begin
            wr_ptr <= top_ptr;
            count  <= count - CNT_W'(1);
          end
        end
        2'b11: begin
          // Top is replaced in place; only an empty stack is flagged.
          if (empty) underflow <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/next_pc_unit.sv
// Program-counter unit: prioritised next-PC selection, PC/EPC registers and a
// shadow return-address stack that cross-checks every jr $ra.
module next_pc_unit
  import mips_pkg::*;
#(
  parameter  int                ADDR_W       = ADDR_W_DEF,
  parameter  logic [ADDR_W-1:0] RESET_VECTOR = ADDR_W'(RESET_VECTOR_DEF),
  parameter  logic [ADDR_W-1:0] EXC_VECTOR   = ADDR_W'(EXC_VECTOR_DEF),
  parameter  int                RAS_DEPTH    = 4,
  localparam int                CNT_W        = $clog2(RAS_DEPTH) + 1
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              stall,
  input  logic [31:0]       instruction,
  input  logic              branch_control,
  input  logic              alu_zero_control,
  input  logic              jump_control,
  input  logic              jr_control,
  input  logic              link_control,
  input  logic              eret_control,
  input  logic              exc_req,
  input  logic [ADDR_W-1:0] read_data1,
  output logic [ADDR_W-1:0] pc,
  output logic [ADDR_W-1:0] pcplus4,
  output logic [ADDR_W-1:0] epc,
  output logic [CNT_W-1:0]  ras_count,
  output logic              ras_mismatch,
  output logic              ras_overflow,
  output logic              ras_underflow
);

  localparam logic [ADDR_W-1:0] LOW28_MASK = ADDR_W'(28'hFFF_FFFF);

  logic signed [ADDR_W-1:0] br_off;
  logic [ADDR_W-1:0]        badder;
  logic [ADDR_W-1:0]        jump_target;
  logic [ADDR_W-1:0]        pc_next;
  logic [ADDR_W-1:0]        ras_top;
  npc_sel_e                 sel;
  logic                     ras_push;
  logic                     ras_pop;
  logic                     unused_opcode;

  assign unused_opcode = &{1'b0, instruction[31:26]};

  assign pcplus4     = pc + ADDR_W'(4);
  assign br_off      = {{(ADDR_W-18){instruction[IMM_MSB]}}, instruction[IMM_MSB:IMM_LSB], 2'b00};
  assign badder      = pcplus4 + $unsigned(br_off);
  assign jump_target = (pcplus4 & ~LOW28_MASK) |
                       ADDR_W'({instruction[JIDX_MSB:JIDX_LSB], 2'b00});

  always_comb begin
    sel = SEL_SEQ;
    if (exc_req)                                 sel = SEL_EXC;
    else if (eret_control)                       sel = SEL_ERET;
    else if (jr_control)                         sel = SEL_JR;
    else if (jump_control)                       sel = SEL_J;
    else if (branch_control && alu_zero_control) sel = SEL_BR;
  end

  always_comb begin
    pc_next = pcplus4;
    case (sel)
      SEL_EXC:  pc_next = EXC_VECTOR;
      SEL_ERET: pc_next = epc;
      SEL_JR:   pc_next = read_data1;
      SEL_J:    pc_next = jump_target;
      SEL_BR:   pc_next = badder;
      default:  pc_next = pcplus4;
    endcase
  end

  // An exception is taken even while stalled.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      pc  <= RESET_VECTOR;
      epc <= '0;
    end else begin
      if (exc_req || !stall) pc <= pc_next;
      if (exc_req)           epc <= pc;
    end
  end

  assign ras_push = link_control & ~stall & ~exc_req & ~eret_control;
  assign ras_pop  = jr_control & (instruction[RS_MSB:RS_LSB] == RA_REG) &
                    ~stall & ~exc_req & ~eret_control;

  ras_stack #(
    .ADDR_W    (ADDR_W),
    .RAS_DEPTH (RAS_DEPTH)
  ) u_ras (
    .clock     (clock),
    .reset_n   (reset_n),
    .push      (ras_push),
    .pop       (ras_pop),
    .push_data (pcplus4),
    .top       (ras_top),
    .count     (ras_count),
    .overflow  (ras_overflow),
    .underflow (ras_underflow)
  );

  assign ras_mismatch = ras_pop & (ras_count != '0) & (ras_top != read_data1);

endmodule

// File: tb/tb_next_pc_unit.sv
// Self-checking bench for next_pc_unit: vector table, directed corner sequences
// and a randomized run against a queue-based reference model.
module tb_next_pc_unit;

  localparam int          AW      = 32;
  localparam int          DEPTH   = 4;
  localparam logic [31:0] EXC_V   = 32'h8000_0180;
  localparam logic [31:0] JR_RA   = 32'h03E0_0008;
  localparam logic [31:0] JAL_100 = 32'h0C00_0100;

  logic          clock;
  logic          reset_n;
  logic          stall;
  logic [31:0]   instruction;
  logic          branch_control;
  logic          alu_zero_control;
  logic          jump_control;
  logic          jr_control;
  logic          link_control;
  logic          eret_control;
  logic          exc_req;
  logic [AW-1:0] read_data1;
  logic [AW-1:0] pc;
  logic [AW-1:0] pcplus4;
  logic [AW-1:0] epc;
  logic [2:0]    ras_count;
  logic          ras_mismatch;
  logic          ras_overflow;
  logic          ras_underflow;

  int checks = 0;
  int errors = 0;

  next_pc_unit #(
    .ADDR_W       (AW),
    .RESET_VECTOR (32'h0000_0000),
    .EXC_VECTOR   (EXC_V),
    .RAS_DEPTH    (DEPTH)
  ) dut (
    .clock            (clock),
    .reset_n          (reset_n),
    .stall            (stall),
    .instruction      (instruction),
    .branch_control   (branch_control),
    .alu_zero_control (alu_zero_control),
    .jump_control     (jump_control),
    .jr_control       (jr_control),
    .link_control     (link_control),
    .eret_control     (eret_control),
    .exc_req          (exc_req),
    .read_data1       (read_data1),
    .pc               (pc),
    .pcplus4          (pcplus4),
    .epc              (epc),
    .ras_count        (ras_count),
    .ras_mismatch     (ras_mismatch),
    .ras_overflow     (ras_overflow),
    .ras_underflow    (ras_underflow)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  typedef struct {
    logic [31:0] start;
    logic [31:0] instr;
    logic        br;
    logic        z;
    logic        j;
    logic        jr;
    logic [31:0] rd1;
    logic [31:0] exp_pc;
  } vec_t;

  vec_t tbl[8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic clr();
    stall = 0; instruction = 0; branch_control = 0; alu_zero_control = 0;
    jump_control = 0; jr_control = 0; link_control = 0; eret_control = 0;
    exc_req = 0; read_data1 = 0;
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic set_pc(input logic [31:0] v);
    clr();
    jr_control = 1; read_data1 = v;
    tick();
    clr();
  endtask

  task automatic jr_ra(input logic [31:0] rd1);
    clr();
    jr_control = 1; instruction = JR_RA; read_data1 = rd1;
    #1;
  endtask

  // Reference model state
  logic [31:0] mpc, mepc, p4, npc;
  logic [31:0] q[$];
  logic        movf, munf, mpush, mpop, mmm;
  int          off;

  initial begin
    tbl[0] = '{32'h0000_0100, 32'h1000_FFFE, 1, 1, 0, 0, 32'h0,         32'h0000_00FC};
    tbl[1] = '{32'h0000_0100, 32'h1000_FFFE, 1, 0, 0, 0, 32'h0,         32'h0000_0104};
    tbl[2] = '{32'h0040_0010, 32'h0800_0100, 0, 0, 1, 0, 32'h0,         32'h0000_0400};
    tbl[3] = '{32'h0000_0500, 32'h0800_0040, 0, 0, 1, 1, 32'h0000_1230, 32'h0000_1230};
    tbl[4] = '{32'h0000_0200, 32'h1000_0010, 1, 1, 0, 0, 32'h0,         32'h0000_0244};
    tbl[5] = '{32'hFFFF_FFFC, 32'h0000_0000, 0, 0, 0, 0, 32'h0,         32'h0000_0000};
    tbl[6] = '{32'hF000_0000, 32'h03FF_FFFF, 0, 0, 1, 0, 32'h0,         32'hFFFF_FFFC};
    tbl[7] = '{32'h0000_0000, 32'h1000_8000, 1, 1, 0, 0, 32'h0,         32'hFFFE_0004};

    clr();
    reset_n = 0;
    #2;
    chk("reset_pc", pc, 32'h0);
    chk("reset_epc", epc, 32'h0);
    chk("reset_cnt", {29'h0, ras_count}, 32'h0);
    chk("reset_ovf", {31'h0, ras_overflow}, 32'h0);
    chk("reset_unf", {31'h0, ras_underflow}, 32'h0);
    tick();
    reset_n = 1;
    tick(); tick();
    chk("run_pc8", pc, 32'h8);
    exc_req = 1;
    tick();
    clr();
    chk("exc_epc", epc, 32'h8);
    link_control = 1;
    tick();
    clr();
    chk("dirty_cnt", {29'h0, ras_count}, 32'h1);

    // Asynchronous reset mid-cycle, observed before any clock edge
    @(negedge clock);
    reset_n = 0;
    #1;
    chk("async_pc", pc, 32'h0);
    chk("async_epc", epc, 32'h0);
    chk("async_cnt", {29'h0, ras_count}, 32'h0);
    @(negedge clock);
    reset_n = 1;
    #1;
    chk("seq_pc0", pc, 32'h0);
    for (int k = 1; k <= 3; k++) begin
      tick();
      chk("seq_pc", pc, 32'(4 * k));
    end

    for (int i = 0; i < 8; i++) begin
      set_pc(tbl[i].start);
      instruction = tbl[i].instr; branch_control = tbl[i].br;
      alu_zero_control = tbl[i].z; jump_control = tbl[i].j;
      jr_control = tbl[i].jr; read_data1 = tbl[i].rd1;
      #1;
      chk("vec_pcplus4", pcplus4, tbl[i].start + 32'd4);
      tick();
      chk("vec_pc", pc, tbl[i].exp_pc);
      clr();
    end

    // jal then matching / mismatching jr $ra
    set_pc(32'h0040_0010);
    jump_control = 1; link_control = 1; instruction = JAL_100;
    tick();
    chk("jal_pc", pc, 32'h0000_0400);
    chk("jal_cnt", {29'h0, ras_count}, 32'h1);
    jr_ra(32'h0040_0014);
    chk("jr_match", {31'h0, ras_mismatch}, 32'h0);
    tick();
    chk("jr_pc", pc, 32'h0040_0014);
    chk("jr_cnt", {29'h0, ras_count}, 32'h0);
    set_pc(32'h0040_0010);
    jump_control = 1; link_control = 1; instruction = JAL_100;
    tick();
    jr_ra(32'h0040_0018);
    chk("jr_mismatch", {31'h0, ras_mismatch}, 32'h1);
    tick();
    clr();

    // Overflow then drain to underflow
    @(negedge clock); reset_n = 0; #1; reset_n = 1;
    link_control = 1;
    for (int k = 0; k < 5; k++) begin
      tick();
      if (k == 3) chk("ovf_at4", {31'h0, ras_overflow}, 32'h0);
    end
    clr();
    chk("ovf_cnt", {29'h0, ras_count}, 32'h4);
    chk("ovf_flag", {31'h0, ras_overflow}, 32'h1);
    for (int k = 0; k < 4; k++) begin
      jr_ra(32'(20 - 4 * k));
      chk("pop_order", {31'h0, ras_mismatch}, 32'h0);
      tick();
    end
    chk("drain_cnt", {29'h0, ras_count}, 32'h0);
    chk("drain_unf", {31'h0, ras_underflow}, 32'h0);
    jr_ra(32'h0000_1234);
    chk("empty_mm", {31'h0, ras_mismatch}, 32'h0);
    tick();
    chk("unf_flag", {31'h0, ras_underflow}, 32'h1);
    chk("unf_cnt", {29'h0, ras_count}, 32'h0);

    // Exception overrides stall, eret returns, stall holds
    set_pc(32'h0000_0200);
    stall = 1; exc_req = 1;
    tick();
    clr();
    chk("exc_pc", pc, EXC_V);
    chk("exc_epc2", epc, 32'h0000_0200);
    eret_control = 1;
    tick();
    clr();
    chk("eret_pc", pc, 32'h0000_0200);
    stall = 1;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("stall_pc", pc, 32'h0000_0200);
    end
    clr();
    link_control = 1;
    tick();
    jr_ra(32'h0000_DEAD);
    stall = 1;
    #1;
    chk("stall_mm", {31'h0, ras_mismatch}, 32'h0);
    tick();
    chk("stall_jr_pc", pc, 32'h0000_0204);
    chk("stall_cnt", {29'h0, ras_count}, 32'h1);
    stall = 0;
    #1;
    chk("unstall_mm", {31'h0, ras_mismatch}, 32'h1);
    tick();
    clr();

    set_pc(32'h0000_0300);
    jump_control = 1; jr_control = 1; exc_req = 1;
    instruction = JAL_100; read_data1 = 32'h0000_1230;
    tick();
    clr();
    chk("prio_exc_pc", pc, EXC_V);
    chk("prio_exc_epc", epc, 32'h0000_0300);

    // Randomized run against the reference model
    @(negedge clock); reset_n = 0; #1; reset_n = 1;
    mpc = 0; mepc = 0; movf = 0; munf = 0; q.delete();
    for (int n = 0; n < 3000; n++) begin
      exc_req          = ($urandom % 32) == 0;
      eret_control     = ($urandom % 20) == 0;
      jr_control       = ($urandom % 8) == 0;
      jump_control     = ($urandom % 8) == 0;
      branch_control   = ($urandom % 4) == 0;
      alu_zero_control = $urandom % 2;
      link_control     = ($urandom % 5) == 0;
      stall            = ($urandom % 8) == 0;
      instruction      = $urandom;
      if ($urandom % 2) instruction[25:21] = 5'd31;
      read_data1 = ((($urandom % 2) == 1) && (q.size() > 0)) ? q[q.size()-1] : $urandom;
      #1;
      p4    = mpc + 32'd4;
      mpop  = jr_control && (instruction[25:21] == 5'd31) && !stall && !exc_req && !eret_control;
      mpush = link_control && !stall && !exc_req && !eret_control;
      mmm   = mpop && (q.size() > 0) && (q[q.size()-1] != read_data1);
      chk("rnd_pcplus4", pcplus4, p4);
      chk("rnd_mismatch", {31'h0, ras_mismatch}, {31'h0, mmm});

      off = $signed(instruction[15:0]);
      if (exc_req)                                 npc = EXC_V;
      else if (stall)                              npc = mpc;
      else if (eret_control)                       npc = mepc;
      else if (jr_control)                         npc = read_data1;
      else if (jump_control)                       npc = (p4 & 32'hF000_0000) | (instruction[25:0] * 4);
      else if (branch_control && alu_zero_control) npc = p4 + 32'(off * 4);
      else                                         npc = p4;
      if (exc_req) mepc = mpc;
      mpc = npc;

      if (mpop && mpush) begin
        if (q.size() == 0) munf = 1;
        else q[q.size()-1] = p4;
      end else if (mpop) begin
        if (q.size() == 0) munf = 1;
        else void'(q.pop_back());
      end else if (mpush) begin
        if (q.size() == DEPTH) begin
          void'(q.pop_front());
          movf = 1;
        end
        q.push_back(p4);
      end

      tick();
      chk("rnd_pc", pc, mpc);
      chk("rnd_epc", epc, mepc);
      chk("rnd_cnt", {29'h0, ras_count}, 32'(q.size()));
      chk("rnd_ovf", {31'h0, ras_overflow}, {31'h0, movf});
      chk("rnd_unf", {31'h0, ras_underflow}, {31'h0, munf});
    end
    clr();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
